key_cmd_ctrl: RTL and testbench
===============================

Name: key_cmd_ctrl

Overview:
Keyboard command controller between the PS/2 scan front end and the gobang game core. It consumes the raw scan-code byte stream and tracks the E0 (extended) and F0 (break) prefixes. It filters typematic repeats, maintains the player cursor on the board, and issues stone-placement requests to the game core over a req/ack handshake. It also emits a new-game pulse on Esc.

Parameters:
BOARD_SIZE, 15, board edge length; cursor range 0..BOARD_SIZE-1
POS_W, 4, cursor coordinate width; requires BOARD_SIZE <= 2**POS_W

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
byte_in  input  8  scan-code byte from the PS/2 receiver
byte_valid  input  1  one-cycle strobe; byte_in is valid in that cycle
enable  input  1  player's turn; when low, moves and places are ignored
place_ack  input  1  game core accepted the pending placement
cur_x  output  POS_W  cursor column
cur_y  output  POS_W  cursor row
place_req  output  1  placement pending; held high until acknowledged
place_x  output  POS_W  latched column of the pending placement
place_y  output  POS_W  latched row of the pending placement
new_game  output  1  one-cycle pulse on an Esc make

Behaviour:
- Reset (async, rst=1):
  - cur_x = cur_y = CENTER = (BOARD_SIZE-1)/2, which is 7 at the default.
  - place_req = 0, place_x = place_y = 0, new_game = 0.
  - Prefix FSM in IDLE; held-key register empty.
- Prefix FSM, advancing only on byte_valid. States are IDLE, EXT, BRK and EXT_BRK.
  - IDLE: E0 -> EXT; F0 -> BRK; other bytes -> make event {ext=0, code}, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other bytes -> make {ext=1, code}, then IDLE.
  - BRK: F0 -> stay BRK; E0 -> EXT_BRK; other bytes -> break {ext=0, code}, then IDLE.
  - EXT_BRK: F0 or E0 -> stay; other bytes -> break {ext=1, code}, then IDLE.
  - Reset mid-sequence discards any partial prefix.
- Typematic filter, using a 9-bit held-key register {ext, code} plus a valid bit.
  - A make equal to the held key is dropped.
  - Any other make is acted on and becomes the held key.
  - A break equal to the held key clears it. Other breaks are ignored.
- Key map (make events only):
  - Up: E0 75 or 1D (W). Down: E0 72 or 1B (S). Left: E0 6B or 1C (A). Right: E0 74 or 23 (D).
  - Place: 29 (Space) or 5A (Enter). New game: 76 (Esc).
  - All other codes, including non-extended 75/72/6B/74, are unmapped and ignored.
- Moves:
  - Applied only when enable=1.
  - Saturating at 0 and BOARD_SIZE-1, with no wrap.
  - Up decrements cur_y, Down increments cur_y, Left decrements cur_x, Right increments cur_x.
  - Outputs update on the clock edge that samples the final byte, so they are visible 1 cycle after the byte_valid strobe.
  - Moves are allowed while place_req is pending; place_x/place_y stay stable.
- Place:
  - Accepted when enable=1 and place_req=0.
  - On acceptance: place_x/place_y <= cur_x/cur_y and place_req <= 1, with the same 1-cycle latency.
  - Place keys while pending, or while enable=0, are ignored.
  - place_ack while place_req=1 clears place_req on the next edge. place_ack while idle is ignored.
  - Ack and a place key in the same cycle: the ack is processed first, then the new place is accepted. place_req stays 1 and place_x/place_y take the new coordinates.
- New game:
  - Independent of enable.
  - new_game pulses for exactly 1 cycle.
  - Same edge: cursor -> CENTER, place_req -> 0. The held key is kept, so Esc auto-repeat gives one pulse.
- enable going low does not cancel a pending place_req.

Decomposition:
- Shared package (ps2_pkg), holding:
  - Scan-code constants: SC_E0, SC_F0, SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT, SC_W, SC_A, SC_S, SC_D, SC_SPACE, SC_ENTER, SC_ESC.
  - Prefix-FSM state enum.
  - Key-event struct {valid, brk, ext, code[7:0]}.
- Sub-module scan_prefix_fsm: the prefix FSM plus the typematic filter. It emits a one-cycle filtered make event, combinational on the byte_valid cycle.
- key_cmd_ctrl: the cursor, place handshake and new-game logic.

Test Plan:
1. Reset, then bytes E0,75 with enable=1 -> cur_y goes 7->6 one cycle after the 75 strobe; cur_x stays 7.
2. Bytes E0,75 x3 (typematic) -> cur_y = 6 only. Then E0,F0,75 followed by E0,75 -> cur_y = 5.
3. Drive cur_y to 0, then Up make/break x2 -> cur_y stays 0. Right x20 -> cur_x saturates at 14.
4. Bytes 29 at cursor (7,7) -> place_req=1, place_x=7, place_y=7.
   - Move right, then press 29 again with place_ack low for 10 cycles -> place_x stays 7 and place_req stays 1.
   - Assert place_ack -> place_req=0 on the next cycle.
5. enable=0, then E0,74 and 29 -> no cursor change, place_req stays 0. Bytes 76 -> new_game high for exactly 1 cycle.
6. Pending place_req at cursor (3,9), then bytes 76 -> place_req=0, cursor=(7,7). Byte E0, assert rst, then byte 75 -> no move (unmapped, non-extended).

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, prefix-FSM states and key-event payload
// for the keyboard command path.
package ps2_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned KEY_W  = CODE_W + 1;

  localparam logic [CODE_W-1:0] SC_E0    = 8'hE0;
  localparam logic [CODE_W-1:0] SC_F0    = 8'hF0;
  localparam logic [CODE_W-1:0] SC_UP    = 8'h75;
  localparam logic [CODE_W-1:0] SC_DOWN  = 8'h72;
  localparam logic [CODE_W-1:0] SC_LEFT  = 8'h6B;
  localparam logic [CODE_W-1:0] SC_RIGHT = 8'h74;
  localparam logic [CODE_W-1:0] SC_W     = 8'h1D;
  localparam logic [CODE_W-1:0] SC_A     = 8'h1C;
  localparam logic [CODE_W-1:0] SC_S     = 8'h1B;
  localparam logic [CODE_W-1:0] SC_D     = 8'h23;
  localparam logic [CODE_W-1:0] SC_SPACE = 8'h29;
  localparam logic [CODE_W-1:0] SC_ENTER = 8'h5A;
  localparam logic [CODE_W-1:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } pfx_state_t;

  typedef struct packed {
    logic              valid;
    logic              brk;
    logic              ext;
    logic [CODE_W-1:0] code;
  } key_evt_t;

endpackage

// File: rtl/scan_prefix_fsm.sv
// Decodes E0/F0 prefixes from the raw scan-code stream and suppresses
// typematic repeats; emits a one-cycle filtered make event.
module scan_prefix_fsm
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output key_evt_t   evt_c
);

  pfx_state_t       state;
  pfx_state_t       state_nxt;
  logic             raw_vld;
  logic             raw_brk;
  logic             raw_ext;
  logic [KEY_W-1:0] raw_key;
  logic             held_vld;
  logic [KEY_W-1:0] held_key;
  logic             held_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      held_vld <= 1'b0;
      held_key <= '0;
    end else begin
      state <= state_nxt;
      if (raw_vld) begin
        if (raw_brk) begin
          if (held_hit) held_vld <= 1'b0;
        end else if (!held_hit) begin
          held_vld <= 1'b1;
          held_key <= raw_key;
        end
      end
    end
  end

  // Prefix bytes only move the state; any other byte completes an event.
  always_comb begin
    state_nxt = state;
    raw_vld   = 1'b0;
    raw_brk   = 1'b0;
    raw_ext   = 1'b0;
    if (byte_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (byte_in == SC_E0)      state_nxt = ST_EXT;
          else if (byte_in == SC_F0) state_nxt = ST_BRK;
          else                       raw_vld   = 1'b1;
        end
        ST_EXT: begin
          if (byte_in == SC_F0) state_nxt = ST_EXT_BRK;
          else if (byte_in != SC_E0) begin
            raw_vld   = 1'b1;
            raw_ext   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (byte_in == SC_E0) state_nxt = ST_EXT_BRK;
          else if (byte_in != SC_F0) begin
            raw_vld   = 1'b1;
            raw_brk   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (byte_in != SC_E0 && byte_in != SC_F0) begin
            raw_vld   = 1'b1;
            raw_brk   = 1'b1;
            raw_ext   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign raw_key  = {raw_ext, byte_in};
  assign held_hit = held_vld && (held_key == raw_key);

  always_comb begin
    evt_c       = '0;
    evt_c.valid = raw_vld && !raw_brk && !held_hit;
    evt_c.ext   = raw_ext;
    evt_c.code  = byte_in;
  end

endmodule

// File: rtl/key_cmd_ctrl.sv
// Keyboard command controller: cursor movement, stone-placement req/ack
// handshake and new-game pulse driven by filtered PS/2 make events.
module key_cmd_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned BOARD_SIZE = 15,
  parameter int unsigned POS_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             enable,
  input  logic             place_ack,
  output logic [POS_W-1:0] cur_x,
  output logic [POS_W-1:0] cur_y,
  output logic             place_req,
  output logic [POS_W-1:0] place_x,
  output logic [POS_W-1:0] place_y,
  output logic             new_game
);

  localparam logic [POS_W-1:0] CENTER  = POS_W'((BOARD_SIZE - 1) / 2);
  localparam logic [POS_W-1:0] MAX_POS = POS_W'(BOARD_SIZE - 1);

  key_evt_t evt_c;
  logic     make_c;
  logic     up_c, down_c, left_c, right_c, place_c, esc_c;

  scan_prefix_fsm u_prefix (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .evt_c      (evt_c)
  );

  // Arrow keys count only when extended; letter/space/enter/esc only when not.
  always_comb begin
    make_c  = evt_c.valid && !evt_c.brk;
    up_c    = make_c && (evt_c.ext ? evt_c.code == SC_UP    : evt_c.code == SC_W);
    down_c  = make_c && (evt_c.ext ? evt_c.code == SC_DOWN  : evt_c.code == SC_S);
    left_c  = make_c && (evt_c.ext ? evt_c.code == SC_LEFT  : evt_c.code == SC_A);
    right_c = make_c && (evt_c.ext ? evt_c.code == SC_RIGHT : evt_c.code == SC_D);
    place_c = make_c && !evt_c.ext && (evt_c.code == SC_SPACE || evt_c.code == SC_ENTER);
    esc_c   = make_c && !evt_c.ext && (evt_c.code == SC_ESC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x     <= CENTER;
      cur_y     <= CENTER;
      place_req <= 1'b0;
      place_x   <= '0;
      place_y   <= '0;
      new_game  <= 1'b0;
    end else begin
      new_game <= 1'b0;
      if (place_req && place_ack) place_req <= 1'b0;
      if (esc_c) begin
        new_game  <= 1'b1;
        cur_x     <= CENTER;
        cur_y     <= CENTER;
        place_req <= 1'b0;
      end else if (enable) begin
        if (up_c    && cur_y != '0)      cur_y <= cur_y - POS_W'(1);
        if (down_c  && cur_y != MAX_POS) cur_y <= cur_y + POS_W'(1);
        if (left_c  && cur_x != '0)      cur_x <= cur_x - POS_W'(1);
        if (right_c && cur_x != MAX_POS) cur_x <= cur_x + POS_W'(1);
        // A same-cycle ack frees the slot for the new placement.
        if (place_c && (!place_req || place_ack)) begin
          place_req <= 1'b1;
          place_x   <= cur_x;
          place_y   <= cur_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Directed and randomized bench for key_cmd_ctrl against a prefix-flag /
// held-key reference model.
module tb_key_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       enable = 1'b1;
  logic       place_ack = 1'b0;
  logic [3:0] cur_x, cur_y, place_x, place_y;
  logic       place_req, new_game;

  int checks = 0;
  int errors = 0;

  // reference model state
  int   m_x, m_y, m_px, m_py;
  bit   m_req, m_ng;
  bit   m_pe, m_pb;
  bit   m_hv;
  int   m_hk;

  key_cmd_ctrl #(.BOARD_SIZE(15), .POS_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .enable     (enable),
    .place_ack  (place_ack),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .place_req  (place_req),
    .place_x    (place_x),
    .place_y    (place_y),
    .new_game   (new_game)
  );

  always #5 clk = ~clk;

  task automatic check_all(input string tag);
    checks++;
    assert (cur_x === 4'(m_x)) else begin
      errors++; $error("FAIL %s cur_x observed %0d expected %0d", tag, cur_x, m_x);
    end
    checks++;
    assert (cur_y === 4'(m_y)) else begin
      errors++; $error("FAIL %s cur_y observed %0d expected %0d", tag, cur_y, m_y);
    end
    checks++;
    assert (place_req === m_req) else begin
      errors++; $error("FAIL %s place_req observed %0b expected %0b", tag, place_req, m_req);
    end
    checks++;
    assert (place_x === 4'(m_px)) else begin
      errors++; $error("FAIL %s place_x observed %0d expected %0d", tag, place_x, m_px);
    end
    checks++;
    assert (place_y === 4'(m_py)) else begin
      errors++; $error("FAIL %s place_y observed %0d expected %0d", tag, place_y, m_py);
    end
    checks++;
    assert (new_game === m_ng) else begin
      errors++; $error("FAIL %s new_game observed %0b expected %0b", tag, new_game, m_ng);
    end
  endtask

  // Apply the meaning of one accepted make key {ext, code}.
  task automatic model_act(input int key);
    case (key)
      'h175, 'h01D: if (enable && m_y > 0)  m_y--;
      'h172, 'h01B: if (enable && m_y < 14) m_y++;
      'h16B, 'h01C: if (enable && m_x > 0)  m_x--;
      'h174, 'h023: if (enable && m_x < 14) m_x++;
      'h029, 'h05A: if (enable && !m_req) begin
        m_req = 1'b1; m_px = m_x; m_py = m_y;
      end
      'h076: begin
        m_ng = 1'b1; m_x = 7; m_y = 7; m_req = 1'b0;
      end
      default: ;
    endcase
  endtask

  // One clock cycle: optional byte, optional ack, then full output check.
  task automatic step(input bit v, input logic [7:0] b, input bit ack, input string tag);
    int key;
    @(negedge clk);
    byte_in = b; byte_valid = v; place_ack = ack;
    m_ng = 1'b0;
    if (m_req && ack) m_req = 1'b0;
    if (v) begin
      if (b == 8'hE0) m_pe = 1'b1;
      else if (b == 8'hF0) m_pb = 1'b1;
      else begin
        key = (m_pe ? 256 : 0) + int'(b);
        if (m_pb) begin
          if (m_hv && m_hk == key) m_hv = 1'b0;
        end else if (!(m_hv && m_hk == key)) begin
          m_hv = 1'b1; m_hk = key;
          model_act(key);
        end
        m_pe = 1'b0; m_pb = 1'b0;
      end
    end
    @(negedge clk);
    byte_valid = 1'b0; place_ack = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    m_x = 7; m_y = 7; m_px = 0; m_py = 0;
    m_req = 1'b0; m_ng = 1'b0; m_pe = 1'b0; m_pb = 1'b0;
    m_hv = 1'b0; m_hk = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; byte_valid = 1'b0; place_ack = 1'b0;
    model_reset();
    #2;
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Press and release a key.
  task automatic tap(input bit ext, input logic [7:0] code, input string tag);
    if (ext) step(1'b1, 8'hE0, 1'b0, tag);
    step(1'b1, code, 1'b0, tag);
    if (ext) step(1'b1, 8'hE0, 1'b0, tag);
    step(1'b1, 8'hF0, 1'b0, tag);
    step(1'b1, code, 1'b0, tag);
  endtask

  logic [7:0] pool [14];

  initial begin
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D,
             8'h1B, 8'h1C, 8'h23, 8'h29, 8'h5A, 8'h76, 8'h11};
    model_reset();

    // 1: reset, single extended Up
    do_reset("reset");
    step(1'b1, 8'hE0, 1'b0, "t1_e0");
    step(1'b1, 8'h75, 1'b0, "t1_up");

    // 2: typematic repeats dropped, release re-arms
    repeat (3) begin
      step(1'b1, 8'hE0, 1'b0, "t2_rep_e0");
      step(1'b1, 8'h75, 1'b0, "t2_rep");
    end
    step(1'b1, 8'hE0, 1'b0, "t2_brk_e0");
    step(1'b1, 8'hF0, 1'b0, "t2_brk_f0");
    step(1'b1, 8'h75, 1'b0, "t2_brk");
    step(1'b1, 8'hE0, 1'b0, "t2_e0");
    step(1'b1, 8'h75, 1'b0, "t2_up");

    // 3: saturation at both ends
    repeat (7) tap(1'b1, 8'h75, "t3_up");
    repeat (2) tap(1'b1, 8'h75, "t3_up_sat");
    repeat (20) tap(1'b1, 8'h74, "t3_right_sat");

    // 4: place, hold while pending, ack
    do_reset("t4_reset");
    step(1'b1, 8'h29, 1'b0, "t4_place");
    step(1'b1, 8'hF0, 1'b0, "t4_rel_f0");
    step(1'b1, 8'h29, 1'b0, "t4_rel");
    tap(1'b1, 8'h74, "t4_right");
    step(1'b1, 8'h29, 1'b0, "t4_place2");
    repeat (10) step(1'b0, 8'h00, 1'b0, "t4_hold");
    step(1'b0, 8'h00, 1'b1, "t4_ack");
    step(1'b0, 8'h00, 1'b1, "t4_ack_idle");
    step(1'b1, 8'hF0, 1'b0, "t4_rel2_f0");
    step(1'b1, 8'h29, 1'b0, "t4_rel2");
    // ack and place in the same cycle
    step(1'b1, 8'h5A, 1'b0, "t4_enter");
    tap(1'b0, 8'h1C, "t4_left");
    step(1'b1, 8'h29, 1'b1, "t4_ack_place");

    // 5: disabled moves/places, Esc pulse
    do_reset("t5_reset");
    enable = 1'b0;
    tap(1'b1, 8'h74, "t5_right_dis");
    tap(1'b0, 8'h29, "t5_place_dis");
    step(1'b1, 8'h76, 1'b0, "t5_esc");
    step(1'b0, 8'h00, 1'b0, "t5_esc_after");
    step(1'b1, 8'h76, 1'b0, "t5_esc_repeat");
    enable = 1'b1;

    // 6: Esc cancels pending place at (3,9); reset clears E0 prefix
    repeat (4) tap(1'b0, 8'h1C, "t6_left");
    repeat (2) tap(1'b0, 8'h1B, "t6_down");
    tap(1'b0, 8'h29, "t6_place");
    step(1'b1, 8'hF0, 1'b0, "t6_esc_rel_f0");
    step(1'b1, 8'h76, 1'b0, "t6_esc_rel");
    step(1'b1, 8'h76, 1'b0, "t6_esc");
    step(1'b1, 8'hE0, 1'b0, "t6_e0");
    do_reset("t6_reset");
    step(1'b1, 8'h75, 1'b0, "t6_plain75");

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int sel;
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      sel = int'($urandom_range(0, 13));
      if (pool[sel] == 8'h76 && $urandom_range(0, 3) != 0) sel = 2;
      step(1'($urandom_range(0, 3) != 0), pool[sel],
           1'($urandom_range(0, 4) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
